// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, HALT drain,
// debug single-step gating, plus stall and cycle counters for the debug unit.
module hazard_stall_controller #(
  parameter int NB_REG       = 5,
  parameter int NB_DATA      = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_STALL     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NB_REG-1:0]   id_rs_i,
  input  logic [NB_REG-1:0]   id_rt_i,
  input  logic                id_ex_mem_read_i,
  input  logic [NB_REG-1:0]   id_ex_write_reg_i,
  input  logic                branch_taken_i,
  input  logic                halt_detected_i,
  input  logic                debug_mode_i,
  input  logic                debug_step_i,
  input  logic                resume_i,
  output logic                pipeline_enable_o,
  output logic                pc_write_o,
  output logic                if_id_write_o,
  output logic                if_id_flush_o,
  output logic                id_ex_bubble_o,
  output logic                halted_o,
  output logic [NB_STALL-1:0] stall_count_o,
  output logic [NB_DATA-1:0]  cycle_count_o
);

  typedef enum logic [1:0] {RUN, STEP_IDLE, DRAIN, HALTED} state_t;

  localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [NB_DRAIN-1:0]   drain_reg, drain_next;
  logic [NB_STALL-1:0]   stall_reg;
  logic [NB_DATA-1:0]    cycle_reg;
  logic                  halted_reg;
  logic                  en;
  logic                  load_use;
  logic                  stall_inc;

  assign load_use = id_ex_mem_read_i && (id_ex_write_reg_i != '0) &&
                    ((id_ex_write_reg_i == id_rs_i) || (id_ex_write_reg_i == id_rt_i));

  always_comb begin
    state_next     = state_reg;
    drain_next     = drain_reg;
    en             = 1'b0;
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    stall_inc      = 1'b0;

    case (state_reg)
      RUN: begin
        en = !debug_mode_i;
        if (debug_mode_i) state_next = STEP_IDLE;
      end
      STEP_IDLE: begin
        en = debug_step_i;
        if (!debug_mode_i) state_next = RUN;
      end
      DRAIN: begin
        en             = 1'b1;
        id_ex_bubble_o = 1'b1;
        if (drain_reg == '0) state_next = HALTED;
        else                 drain_next = drain_reg - NB_DRAIN'(1);
      end
      HALTED: begin
        if (resume_i) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    // Strobe priority for ordinary enabled cycles; a HALT here overrides any step-mode exit.
    if (en && state_reg != DRAIN) begin
      if (branch_taken_i) begin
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
      end else if (load_use) begin
        id_ex_bubble_o = 1'b1;
        stall_inc      = 1'b1;
      end else if (halt_detected_i) begin
        id_ex_bubble_o = 1'b1;
        state_next     = DRAIN;
        drain_next     = DRAIN_LOAD;
      end else begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      drain_reg  <= '0;
      stall_reg  <= '0;
      cycle_reg  <= '0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      drain_reg  <= drain_next;
      if (stall_inc && stall_reg != '1) stall_reg <= stall_reg + NB_STALL'(1);
      if (en) cycle_reg <= cycle_reg + NB_DATA'(1);
      // Raised after the first full cycle spent in HALTED, dropped on resume.
      halted_reg <= (state_reg == HALTED) && !resume_i;
    end
  end

  assign pipeline_enable_o = en;
  assign halted_o          = halted_reg;
  assign stall_count_o     = stall_reg;
  assign cycle_count_o     = cycle_reg;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: hazards, branch priority, HALT drain,
// step mode, asynchronous reset and stall-counter saturation.
module tb_hazard_stall_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs_i, id_rt_i, id_ex_write_reg_i;
  logic        id_ex_mem_read_i, branch_taken_i, halt_detected_i;
  logic        debug_mode_i, debug_step_i, resume_i;
  logic        pipeline_enable_o, pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, halted_o;
  logic [15:0] stall_count_o;
  logic [31:0] cycle_count_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] c0;

  always #5 clock = ~clock;

  hazard_stall_controller dut (
    .clock(clock), .reset(reset),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_ex_mem_read_i(id_ex_mem_read_i), .id_ex_write_reg_i(id_ex_write_reg_i),
    .branch_taken_i(branch_taken_i), .halt_detected_i(halt_detected_i),
    .debug_mode_i(debug_mode_i), .debug_step_i(debug_step_i), .resume_i(resume_i),
    .pipeline_enable_o(pipeline_enable_o), .pc_write_o(pc_write_o),
    .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_bubble_o(id_ex_bubble_o), .halted_o(halted_o),
    .stall_count_o(stall_count_o), .cycle_count_o(cycle_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_rs_i = '0; id_rt_i = '0; id_ex_write_reg_i = '0;
    id_ex_mem_read_i = 0; branch_taken_i = 0; halt_detected_i = 0;
    debug_mode_i = 0; debug_step_i = 0; resume_i = 0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #3;
    chk("rst_en", 32'(pipeline_enable_o), 32'd1);
    chk("rst_pcw", 32'(pc_write_o), 32'd1);
    chk("rst_bubble", 32'(id_ex_bubble_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_stall", 32'(stall_count_o), 32'd0);
    chk("rst_cycle", cycle_count_o, 32'd0);
    #9 reset = 1'b0;
    cyc();
    $display("reset released cycle=%0d", cycle_count_o);
    chk("cycle_after_rst", cycle_count_o, 32'd1);

    // Load-use on rs
    id_ex_mem_read_i = 1; id_ex_write_reg_i = 5; id_rs_i = 5; #1;
    chk("lu_pcw", 32'(pc_write_o), 32'd0);
    chk("lu_ifidw", 32'(if_id_write_o), 32'd0);
    chk("lu_bubble", 32'(id_ex_bubble_o), 32'd1);
    chk("lu_flush", 32'(if_id_flush_o), 32'd0);
    cyc();
    $display("load-use rs=5 stall=%0d", stall_count_o);
    chk("lu_stall1", 32'(stall_count_o), 32'd1);

    // Destination r0 never hazards
    id_ex_write_reg_i = 0; id_rs_i = 0; #1;
    chk("r0_pcw", 32'(pc_write_o), 32'd1);
    chk("r0_bubble", 32'(id_ex_bubble_o), 32'd0);
    cyc();
    $display("load r0 stall=%0d", stall_count_o);
    chk("r0_stall", 32'(stall_count_o), 32'd1);

    // Load-use on rt
    id_ex_write_reg_i = 7; id_rt_i = 7; id_rs_i = 3; #1;
    chk("lu_rt_ifidw", 32'(if_id_write_o), 32'd0);
    cyc();
    $display("load-use rt=7 stall=%0d", stall_count_o);
    chk("lu_rt_stall", 32'(stall_count_o), 32'd2);

    // Register match without a load
    id_ex_mem_read_i = 0; #1;
    chk("nold_pcw", 32'(pc_write_o), 32'd1);
    cyc();
    chk("nold_stall", 32'(stall_count_o), 32'd2);

    // Branch + load-use + halt together: branch wins
    idle();
    branch_taken_i = 1; id_ex_mem_read_i = 1; id_ex_write_reg_i = 5; id_rs_i = 5; halt_detected_i = 1; #1;
    chk("br_flush", 32'(if_id_flush_o), 32'd1);
    chk("br_bubble", 32'(id_ex_bubble_o), 32'd1);
    chk("br_pcw", 32'(pc_write_o), 32'd1);
    chk("br_ifidw", 32'(if_id_write_o), 32'd1);
    cyc();
    idle(); #1;
    $display("branch+lu+halt stall=%0d en=%0d", stall_count_o, pipeline_enable_o);
    chk("br_stall", 32'(stall_count_o), 32'd2);
    chk("br_run_pcw", 32'(pc_write_o), 32'd1);
    chk("br_run_bubble", 32'(id_ex_bubble_o), 32'd0);
    cyc();

    // Load-use + halt: stall first, halt re-seen next cycle
    id_ex_mem_read_i = 1; id_ex_write_reg_i = 5; id_rs_i = 5; halt_detected_i = 1; #1;
    chk("luh_pcw", 32'(pc_write_o), 32'd0);
    cyc();
    chk("luh_stall", 32'(stall_count_o), 32'd3);
    id_ex_mem_read_i = 0; #1;
    chk("halt_pcw", 32'(pc_write_o), 32'd0);
    chk("halt_bubble", 32'(id_ex_bubble_o), 32'd1);
    c0 = cycle_count_o;
    cyc();  // edge ending the halt-detect cycle
    idle();
    branch_taken_i = 1; id_ex_mem_read_i = 1; id_ex_write_reg_i = 5; id_rs_i = 5; #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_en", 32'(pipeline_enable_o), 32'd1);
      chk("drain_flush", 32'(if_id_flush_o), 32'd0);
      chk("drain_pcw", 32'(pc_write_o), 32'd0);
      chk("drain_bubble", 32'(id_ex_bubble_o), 32'd1);
      cyc();
    end
    idle(); #1;
    $display("after 4 drain edges en=%0d halted=%0d", pipeline_enable_o, halted_o);
    chk("halted_edge4", 32'(halted_o), 32'd0);
    chk("halted_en", 32'(pipeline_enable_o), 32'd0);
    cyc();
    $display("after 5 edges halted=%0d cycle delta=%0d", halted_o, cycle_count_o - c0);
    chk("halted_edge5", 32'(halted_o), 32'd1);
    chk("halt_cycles", cycle_count_o - c0, 32'd5);
    chk("halted_pcw", 32'(pc_write_o), 32'd0);
    chk("halted_bubble", 32'(id_ex_bubble_o), 32'd0);
    cyc();
    chk("halted_frozen", cycle_count_o - c0, 32'd5);
    resume_i = 1; debug_step_i = 1;
    cyc();
    idle(); #1;
    $display("resume en=%0d halted=%0d", pipeline_enable_o, halted_o);
    chk("resume_en", 32'(pipeline_enable_o), 32'd1);
    chk("resume_halted", 32'(halted_o), 32'd0);
    chk("resume_pcw", 32'(pc_write_o), 32'd1);
    cyc();

    // Step mode: 10 cycles, 3 step pulses
    c0 = cycle_count_o;
    debug_mode_i = 1;
    for (int i = 0; i < 10; i++) begin
      debug_step_i = (i == 3 || i == 6 || i == 9); #1;
      chk("step_en", 32'(pipeline_enable_o), 32'(debug_step_i));
      cyc();
    end
    debug_step_i = 0;
    $display("step mode cycle delta=%0d", cycle_count_o - c0);
    chk("step_cycles", cycle_count_o - c0, 32'd3);
    debug_mode_i = 0; #1;
    chk("step_exit_en", 32'(pipeline_enable_o), 32'd0);
    cyc();
    chk("step_run_en", 32'(pipeline_enable_o), 32'd1);

    // Asynchronous reset in the middle of DRAIN
    halt_detected_i = 1;
    cyc();
    halt_detected_i = 0;
    cyc();
    cyc();
    #2 reset = 1'b1;
    #1;
    $display("mid-drain reset halted=%0d stall=%0d cycle=%0d", halted_o, stall_count_o, cycle_count_o);
    chk("mdr_halted", 32'(halted_o), 32'd0);
    chk("mdr_stall", 32'(stall_count_o), 32'd0);
    chk("mdr_cycle", cycle_count_o, 32'd0);
    chk("mdr_pcw", 32'(pc_write_o), 32'd1);
    #1 reset = 1'b0;
    cyc();
    chk("mdr_run_pcw", 32'(pc_write_o), 32'd1);
    chk("mdr_run_cycle", cycle_count_o, 32'd1);

    // Stall counter saturation
    id_ex_mem_read_i = 1; id_ex_write_reg_i = 9; id_rt_i = 9;
    repeat (65539) cyc();
    $display("saturation stall=%0h", stall_count_o);
    chk("sat_stall", 32'(stall_count_o), 32'h0000_FFFF);
    chk("sat_pcw", 32'(pc_write_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the 5-stage MIPS core. Detects load-use hazards that register forwarding cannot cover and inserts one bubble. Applies taken-branch flushes, and drains the pipeline on a HALT instruction. Gates the global pipeline enable for debug single-step mode, and exposes stall and cycle counters to the debug unit. Sits beside the forwarding logic in ID and drives the PC, IF/ID and ID/EX register controls.

## Interface
- NB_REG, 5, register index width
- NB_DATA, 32, cycle counter width
- DRAIN_CYCLES, 4, cycles needed to retire in-flight instructions after HALT reaches ID (≥1)
- NB_STALL, 16, stall counter width
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high reset
- id_rs_i  input  NB_REG  rs of instruction in ID
- id_rt_i  input  NB_REG  rt of instruction in ID
- id_ex_mem_read_i  input  1  instruction in EX is a load
- id_ex_write_reg_i  input  NB_REG  destination register of instruction in EX
- branch_taken_i  input  1  branch/jump resolved taken this cycle
- halt_detected_i  input  1  HALT opcode in ID
- debug_mode_i  input  1  level; 1 = single-step mode
- debug_step_i  input  1  one-cycle pulse; advance pipeline one cycle in step mode
- resume_i  input  1  one-cycle pulse; leave HALTED
- pipeline_enable_o  output  1  global enable for all pipeline registers and PC
- pc_write_o  output  1  PC load enable
- if_id_write_o  output  1  IF/ID load enable
- if_id_flush_o  output  1  clear IF/ID to NOP
- id_ex_bubble_o  output  1  load NOP control word into ID/EX
- halted_o  output  1  pipeline drained and stopped
- stall_count_o  output  NB_STALL  saturating count of load-use stall cycles
- cycle_count_o  output  NB_DATA  wrapping count of enabled cycles

## Operation
- States: RUN, STEP_IDLE, DRAIN, HALTED. Reset state RUN.
- pipeline_enable_o ("en") is 1 in RUN with debug_mode_i=0, in STEP_IDLE while debug_step_i=1, and always in DRAIN. It is 0 otherwise.
- Load-use hazard ("lu"): id_ex_mem_read_i=1, id_ex_write_reg_i≠0, and id_ex_write_reg_i equals id_rs_i or id_rt_i.
- Strobe priority applies only in cycles with en=1 and state≠DRAIN. It is evaluated in this order:
  1. branch_taken_i: if_id_flush_o=1 and id_ex_bubble_o=1. pc_write_o=1 and if_id_write_o=1. halt_detected_i and lu are ignored.
  2. lu: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1. stall_count_o increments and saturates at all-ones. halt_detected_i is ignored; it is re-seen next cycle.
  3. halt_detected_i: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1. Next state is DRAIN with the drain counter loaded to DRAIN_CYCLES-1.
  4. Otherwise: pc_write_o=1, if_id_write_o=1, flush=0, bubble=0.
- DRAIN: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, if_id_flush_o=0. All inputs except reset are ignored. The counter decrements each cycle; when the counter is 0, the next state is HALTED.
- HALTED: en=0, all strobes 0, halted_o=1. A resume_i pulse moves the state to RUN; the PC is still frozen at the HALT instruction's successor.
- RUN with debug_mode_i=1: en=0 and next state is STEP_IDLE.
- STEP_IDLE with debug_mode_i=0: next state is RUN.
- STEP_IDLE with debug_step_i=1: the cycle is processed as a normal enabled cycle, and a HALT seen in that cycle enters DRAIN.
- When en=0, all strobes are 0 and no counter changes.
- cycle_count_o increments on every en=1 cycle, including DRAIN, and wraps.

## Timing
- All strobes and en are combinational (Mealy) from the current state and the inputs in the same cycle. State and counters update on the rising clock edge.
- Load-use costs exactly 1 bubble cycle. The next cycle re-evaluates; the load is then in MEM and is covered by forwarding.
- Taken branch: 1-cycle flush, no stall.
- HALT: halted_o rises exactly DRAIN_CYCLES+1 edges after the edge that ends the halt-detect cycle.
- Reset is asynchronous and may occur mid-DRAIN or in HALTED. It forces:
  - state RUN
  - drain counter 0, stall_count_o 0, cycle_count_o 0, halted_o 0
  - strobes follow RUN decoding of the inputs: with idle inputs, en=1, pc_write_o=1, if_id_write_o=1, flush=0, bubble=0.
- Simultaneous debug_step_i and resume_i in HALTED: resume_i wins. debug_step_i is ignored outside STEP_IDLE.

## Test plan
- Load-use: mem_read=1, ex_wr=5, rs=5 for one cycle. Required: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 that cycle, and stall_count_o goes 0→1. Repeat with ex_wr=0: no stall.
- Branch plus hazard plus halt all in one cycle: if_id_flush_o=1, bubble=1, pc_write_o=1, stall_count_o unchanged, state stays RUN.
- HALT with DRAIN_CYCLES=4: halted_o=1 exactly 5 edges later, and cycle_count_o has advanced by 5. A later resume_i pulse returns to RUN with en=1.
- Step mode: debug_mode_i=1 for 10 cycles with 3 debug_step_i pulses. Required: cycle_count_o advances by exactly 3, and en is high only in the pulse cycles.
- Reset asserted asynchronously mid-DRAIN, between clock edges. Required: halted_o=0 and counters 0 immediately; after release, RUN with pc_write_o=1.
- Saturation: force 2^16+3 consecutive load-use cycles. Required: stall_count_o holds at 0xFFFF.
